// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator: extends instruction immediates to XLEN and
// presents them one cycle later behind a valid/ready handshake with a 2-entry skid.
module imm_ext_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:7]      i_instr,
  input  logic [2:0]       i_immsrc,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_immext,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } item_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  item_t  out_q, skid_q, new_item;
  logic   [XLEN-1:0] imm;
  logic   imm_illegal;
  logic   accept, emit;
  logic   load_out, out_from_skid, load_skid;

  // Immediate extraction; signed casts sign-extend from instr[31]
  always_comb begin
    imm         = '0;
    imm_illegal = 1'b0;
    case (i_immsrc)
      3'b000: imm = XLEN'($signed(i_instr[31:20]));
      3'b001: imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      3'b010: imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                   i_instr[11:8], 1'b0}));
      3'b011: imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                   i_instr[30:21], 1'b0}));
      3'b100: imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      3'b101: begin
        if (XLEN == 32) begin
          imm         = XLEN'(i_instr[24:20]);
          imm_illegal = i_instr[25];
        end else begin
          imm = XLEN'(i_instr[25:20]);
        end
      end
      3'b110:  imm = XLEN'(i_instr[19:15]);
      default: imm_illegal = 1'b1;
    endcase
  end

  always_comb begin
    new_item.imm     = imm;
    new_item.tag     = i_tag;
    new_item.illegal = imm_illegal;
  end

  assign accept = i_valid & o_ready;
  assign emit   = o_valid & i_ready;

  // Next-state and storage steering
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && emit) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = S_FULL;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (emit) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_d       = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State, handshake flags and payload registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= (state_d != S_EMPTY);
      o_ready <= (state_d != S_FULL);
      if (load_out) out_q <= out_from_skid ? skid_q : new_item;
      if (load_skid) skid_q <= new_item;
    end
  end

  assign o_immext  = out_q.imm;
  assign o_tag     = out_q.tag;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// checked against a queue-based FIFO model with arithmetic immediate decoding.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, rdy;
  logic [31:7] instr;
  logic [2:0]  src;
  logic [31:0] tag;

  logic        ordy32, ov32, oill32;
  logic [31:0] oimm32, otag32;
  logic        ordy64, ov64, oill64;
  logic [63:0] oimm64;
  logic [31:0] otag64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy32),
    .i_instr(instr), .i_immsrc(src), .i_tag(tag), .o_valid(ov32),
    .i_ready(rdy), .o_immext(oimm32), .o_tag(otag32), .o_illegal(oill32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy64),
    .i_instr(instr), .i_immsrc(src), .i_tag(tag), .o_valid(ov64),
    .i_ready(rdy), .o_immext(oimm64), .o_tag(otag64), .o_illegal(oill64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic        ill32;
    logic [63:0] imm64;
    logic        ill64;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [31:0] e32;
    logic        i32;
    logic [63:0] e64;
    logic        i64;
  } vec_t;

  exp_t        q[$];
  int          emit_cyc[$];
  logic [31:0] emit_tag[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          checking = 0;
  bit          last_acc = 0;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Immediate decode by shifting and masking the whole instruction word
  function automatic exp_t model(input logic [31:7] ins, input logic [2:0] s,
                                 input logic [31:0] t);
    logic [31:0] word;
    longint      w, v;
    exp_t        e;
    word = {ins, 7'b0};
    w = longint'($signed(word));
    e.ill32 = 1'b0;
    e.ill64 = 1'b0;
    v = 0;
    case (s)
      3'd0: v = w >>> 20;
      3'd1: v = ((w >>> 25) <<< 5) | ((w >> 7) & 31);
      3'd2: v = ((w >>> 31) <<< 12) | (((w >> 7) & 1) << 11)
              | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
      3'd3: v = ((w >>> 31) <<< 20) | (((w >> 12) & 255) << 12)
              | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
      3'd4: v = w & ~longint'(4095);
      3'd6: v = (w >> 15) & 31;
      default: v = 0;
    endcase
    e.imm32 = 32'(v);
    e.imm64 = 64'(v);
    if (s == 3'd5) begin
      e.imm32 = 32'((w >> 20) & 31);
      e.ill32 = ((w >> 25) & 1) != 0;
      e.imm64 = 64'((w >> 20) & 63);
    end
    if (s == 3'd7) begin
      e.ill32 = 1'b1;
      e.ill64 = 1'b1;
    end
    e.tag = t;
    return e;
  endfunction

  task automatic check_model();
    chk("valid32", 64'(ov32), 64'(q.size() > 0));
    chk("ready32", 64'(ordy32), 64'(q.size() < 2));
    chk("valid64", 64'(ov64), 64'(q.size() > 0));
    chk("ready64", 64'(ordy64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("imm32", 64'(oimm32), 64'(q[0].imm32));
      chk("ill32", 64'(oill32), 64'(q[0].ill32));
      chk("tag32", 64'(otag32), 64'(q[0].tag));
      chk("imm64", oimm64, q[0].imm64);
      chk("ill64", 64'(oill64), 64'(q[0].ill64));
      chk("tag64", 64'(otag64), 64'(q[0].tag));
    end
  endtask

  // One clock: check at negedge, update the model at posedge, return #1 later
  task automatic tick();
    bit acc, emi;
    @(negedge clk);
    if (checking && !rst) check_model();
    acc = !rst && valid && (q.size() < 2);
    emi = !rst && (q.size() > 0) && rdy;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (emi) begin
        emit_cyc.push_back(cyc);
        emit_tag.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (acc) q.push_back(model(instr, src, tag));
    end
    last_acc = acc;
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_valid"}, 64'(ov32), 64'd0);
    chk({pfx, "_ready"}, 64'(ordy32), 64'd1);
    chk({pfx, "_imm32"}, 64'(oimm32), 64'd0);
    chk({pfx, "_tag"}, 64'(otag32), 64'd0);
    chk({pfx, "_ill"}, 64'(oill32), 64'd0);
    chk({pfx, "_imm64"}, oimm64, 64'd0);
    chk({pfx, "_valid64"}, 64'(ov64), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    tbl[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{32'h7FF00093, 3'd0, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
    tbl[2]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[3]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[4]  = '{32'hFFDFF0EF, 3'd3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    tbl[5]  = '{32'h800000B7, 3'd4, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    tbl[6]  = '{32'h12345037, 3'd4, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    tbl[7]  = '{32'h01F09093, 3'd5, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    tbl[8]  = '{32'h03F09093, 3'd5, 32'h0000001F, 1'b1, 64'h000000000000003F, 1'b0};
    tbl[9]  = '{32'h000F8073, 3'd6, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    tbl[11] = '{32'h0080006F, 3'd3, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};

    rst = 1'b1; valid = 1'b0; rdy = 1'b0; instr = '0; src = '0; tag = '0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    checking = 1'b1;
    chk_reset_state("reset");

    // Table vectors, one at a time with the sink ready
    rdy = 1'b1;
    foreach (tbl[i]) begin
      w = tbl[i].ins;
      valid = 1'b1; instr = w[31:7]; src = tbl[i].src; tag = 32'hA000 + 32'(i);
      tick();
      valid = 1'b0; instr = 25'($urandom); src = 3'($urandom);
      chk($sformatf("tbl%0d_valid", i), 64'(ov32), 64'd1);
      chk($sformatf("tbl%0d_imm32", i), 64'(oimm32), 64'(tbl[i].e32));
      chk($sformatf("tbl%0d_ill32", i), 64'(oill32), 64'(tbl[i].i32));
      chk($sformatf("tbl%0d_imm64", i), oimm64, tbl[i].e64);
      chk($sformatf("tbl%0d_ill64", i), 64'(oill64), 64'(tbl[i].i64));
      tick();
    end

    // Backpressure: A presented, B skidded, C held upstream
    rdy = 1'b0;
    emit_cyc.delete(); emit_tag.delete();
    valid = 1'b1; instr = 25'($urandom); src = 3'($urandom_range(0, 6)); tag = 32'hA;
    tick();
    instr = 25'($urandom); src = 3'($urandom_range(0, 6)); tag = 32'hB;
    tick();
    instr = 25'($urandom); src = 3'($urandom_range(0, 6)); tag = 32'hC;
    tick();
    chk("bp_ready_low", 64'(ordy32), 64'd0);
    chk("bp_tag_a", 64'(otag32), 64'hA);
    tick();
    tick();
    chk("bp_hold_tag_a", 64'(otag32), 64'hA);
    chk("bp_hold_ready", 64'(ordy64), 64'd0);
    rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc) break;
    end
    chk("bp_c_accepted", 64'(last_acc), 64'd1);
    valid = 1'b0;
    repeat (3) tick();
    chk("bp_emit_count", 64'(emit_tag.size()), 64'd3);
    if (emit_tag.size() == 3) begin
      chk("bp_order0", 64'(emit_tag[0]), 64'hA);
      chk("bp_order1", 64'(emit_tag[1]), 64'hB);
      chk("bp_order2", 64'(emit_tag[2]), 64'hC);
      chk("bp_gap01", 64'(emit_cyc[1] - emit_cyc[0]), 64'd1);
      chk("bp_gap12", 64'(emit_cyc[2] - emit_cyc[1]), 64'd1);
    end

    // Reset while FULL discards both held items
    rdy = 1'b0;
    valid = 1'b1; instr = 25'($urandom); src = 3'd0; tag = 32'hE1;
    tick();
    tag = 32'hE2;
    tick();
    chk("full_ready_low", 64'(ordy32), 64'd0);
    rst = 1'b1; tag = 32'hE3;
    tick();
    rst = 1'b0; valid = 1'b0;
    chk_reset_state("rst_full");
    emit_cyc.delete(); emit_tag.delete();
    w = 32'hFFF00093;
    valid = 1'b1; instr = w[31:7]; src = 3'd0; tag = 32'hD; rdy = 1'b1;
    tick();
    valid = 1'b0;
    chk("d_valid", 64'(ov32), 64'd1);
    chk("d_tag", 64'(otag32), 64'hD);
    chk("d_imm", 64'(oimm32), 64'hFFFFFFFF);
    tick();
    chk("d_emit_count", 64'(emit_tag.size()), 64'd1);
    if (emit_tag.size() == 1) chk("d_emit_tag", 64'(emit_tag[0]), 64'hD);
    chk("d_drained", 64'(ov32), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      valid = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      instr = 25'($urandom);
      src   = 3'($urandom);
      tag   = $urandom;
      if (k % 997 == 500) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    valid = 1'b0; rdy = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
